// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared types and widths for the pipeline hazard controller.
// Contents:
//   ctrl_state_t - sequencer states (INIT=0, RUN=1, MEM_WAIT=2)
//   REG_IDX_W    - architectural register index width
//   INIT_CNT_W   - width of the post-reset clearing counter
//   WAIT_CNT_W   - width of the saturating dmem wait counter
//   PERF_CNT_W   - width of the optional performance counters
package pipeline_ctrl_pkg;
   typedef enum logic [1:0] {
      INIT     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2
   } ctrl_state_t;
   localparam int REG_IDX_W  = 5;
   localparam int INIT_CNT_W = 4;
   localparam int WAIT_CNT_W = 8;
   localparam int PERF_CNT_W = 32;
endpackage

// File: rtl/hazard_perf_counter.sv
// hazard_perf_counter: enable-increment counter that wraps modulo 2^W.
// Ports:
//   clk     - system clock
//   reset_n - asynchronous active-low reset, clears the count
//   inc_i   - increment this cycle
//   count_o - current count
module hazard_perf_counter
   import pipeline_ctrl_pkg::*;
#(
   parameter int W = PERF_CNT_W
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) count_q <= '0;
      else if (inc_i) count_q <= count_q + W'(1);
   assign count_o = count_q;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined;
// otherwise stall_cycles/flush_events are tied to 0.
// Ports:
//   clk, reset_n                    - clock, asynchronous active-low reset
//   ID_rs1/ID_rs2, ID_uses_rs1/2    - source operands of the instruction in ID
//   EX_cntl_MemRead, EX_WriteRegNum - load indication and destination in EX
//   EX_branch_taken                 - redirect resolved in EX
//   MEM_mem_req, dmem_ready         - data memory handshake of the MEM stage
//   PC_en, IF_ID_en, ID_EX_en, EX_MEM_en           - pipeline register enables
//   IF_ID_flush, ID_EX_flush, MEM_WB_bubble        - NOP/bubble insertion
//   dmem_timeout                    - sticky data memory timeout flag
//   stall_cycles, flush_events      - performance counters
module pipeline_hazard_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int INIT_CYCLES  = 4,
   parameter int DMEM_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [REG_IDX_W-1:0]  ID_rs1,
   input  logic [REG_IDX_W-1:0]  ID_rs2,
   input  logic                  ID_uses_rs1,
   input  logic                  ID_uses_rs2,
   input  logic                  EX_cntl_MemRead,
   input  logic [REG_IDX_W-1:0]  EX_WriteRegNum,
   input  logic                  EX_branch_taken,
   input  logic                  MEM_mem_req,
   input  logic                  dmem_ready,
   output logic                  PC_en,
   output logic                  IF_ID_en,
   output logic                  IF_ID_flush,
   output logic                  ID_EX_en,
   output logic                  ID_EX_flush,
   output logic                  EX_MEM_en,
   output logic                  MEM_WB_bubble,
   output logic                  dmem_timeout,
   output logic [PERF_CNT_W-1:0] stall_cycles,
   output logic [PERF_CNT_W-1:0] flush_events
);
   localparam logic [INIT_CNT_W-1:0] INIT_LAST = INIT_CNT_W'(INIT_CYCLES - 1);
   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(DMEM_TIMEOUT - 1);
   localparam logic [WAIT_CNT_W-1:0] WAIT_MAX  = '1;
   ctrl_state_t             state_q, state_d;
   logic [INIT_CNT_W-1:0]   init_cnt_q, init_cnt_d;
   logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic                    timeout_q, timeout_d;
   logic                    mem_stall, load_use;
   assign mem_stall = MEM_mem_req & ~dmem_ready;
   // x0 is never a real producer, so it cannot create a load-use dependency
   assign load_use  = EX_cntl_MemRead & (EX_WriteRegNum != '0) &
                      ((ID_uses_rs1 & (ID_rs1 == EX_WriteRegNum)) |
                       (ID_uses_rs2 & (ID_rs2 == EX_WriteRegNum)));
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   always_comb begin
      state_d       = state_q;
      init_cnt_d    = init_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_d     = timeout_q;
      PC_en         = 1'b1;
      IF_ID_en      = 1'b1;
      ID_EX_en      = 1'b1;
      EX_MEM_en     = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_flush   = 1'b0;
      MEM_WB_bubble = 1'b0;
      if (state_q == INIT) begin
         PC_en         = 1'b0;
         IF_ID_flush   = 1'b1;
         ID_EX_flush   = 1'b1;
         MEM_WB_bubble = 1'b1;
         init_cnt_d    = init_cnt_q + INIT_CNT_W'(1);
         if (init_cnt_q == INIT_LAST) state_d = RUN;
      end else if (mem_stall) begin
         // freeze everything upstream of MEM; a pending branch or load-use
         // stays in EX/ID and is acted on once the access completes
         PC_en         = 1'b0;
         IF_ID_en      = 1'b0;
         ID_EX_en      = 1'b0;
         EX_MEM_en     = 1'b0;
         MEM_WB_bubble = 1'b1;
         state_d       = MEM_WAIT;
         wait_cnt_d    = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_CNT_W'(1);
         if (wait_cnt_q == WAIT_LAST) timeout_d = 1'b1;
      end else begin
         state_d    = RUN;
         wait_cnt_d = '0;
         if (EX_branch_taken) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
         end else if (load_use) begin
            PC_en       = 1'b0;
            IF_ID_en    = 1'b0;
            ID_EX_flush = 1'b1;
         end
      end
   end
   assign dmem_timeout = timeout_q;
`ifdef HAZARD_PERF_CNT_EN
   logic stall_inc, flush_inc;
   assign stall_inc = (state_q != INIT) & ~PC_en;
   assign flush_inc = (state_q != INIT) & ~mem_stall & EX_branch_taken;
   hazard_perf_counter #(.W(PERF_CNT_W)) u_stall_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (stall_inc),
      .count_o (stall_cycles)
   );
   hazard_perf_counter #(.W(PERF_CNT_W)) u_flush_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (flush_inc),
      .count_o (flush_events)
   );
`else
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF_ON = 1'b1;
`else
   localparam bit PERF_ON = 1'b0;
`endif
   // {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble}
   localparam logic [6:0] C_INIT  = 7'b0111111;
   localparam logic [6:0] C_RUN   = 7'b1101010;
   localparam logic [6:0] C_LU    = 7'b0001110;
   localparam logic [6:0] C_BR    = 7'b1111110;
   localparam logic [6:0] C_STALL = 7'b0000001;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  ID_rs1, ID_rs2, EX_WriteRegNum;
   logic        ID_uses_rs1, ID_uses_rs2, EX_cntl_MemRead, EX_branch_taken;
   logic        MEM_mem_req, dmem_ready;
   logic        PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble;
   logic        dmem_timeout;
   logic [31:0] stall_cycles, flush_events;
   logic [6:0]  ctl;
   int          tests = 0;
   int          failed = 0;
   int          exp_stall = 0;
   int          exp_flush = 0;
   pipeline_hazard_ctrl #(.INIT_CYCLES(4), .DMEM_TIMEOUT(8)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .ID_rs1          (ID_rs1),
      .ID_rs2          (ID_rs2),
      .ID_uses_rs1     (ID_uses_rs1),
      .ID_uses_rs2     (ID_uses_rs2),
      .EX_cntl_MemRead (EX_cntl_MemRead),
      .EX_WriteRegNum  (EX_WriteRegNum),
      .EX_branch_taken (EX_branch_taken),
      .MEM_mem_req     (MEM_mem_req),
      .dmem_ready      (dmem_ready),
      .PC_en           (PC_en),
      .IF_ID_en        (IF_ID_en),
      .IF_ID_flush     (IF_ID_flush),
      .ID_EX_en        (ID_EX_en),
      .ID_EX_flush     (ID_EX_flush),
      .EX_MEM_en       (EX_MEM_en),
      .MEM_WB_bubble   (MEM_WB_bubble),
      .dmem_timeout    (dmem_timeout),
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events)
   );
   assign ctl = {PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush, EX_MEM_en, MEM_WB_bubble};
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic clear_in();
      ID_rs1 = '0; ID_rs2 = '0; EX_WriteRegNum = '0;
      ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0; EX_cntl_MemRead = 1'b0;
      EX_branch_taken = 1'b0; MEM_mem_req = 1'b0; dmem_ready = 1'b0;
   endtask
   function automatic logic [31:0] pv(input int v);
      return PERF_ON ? 32'(v) : 32'd0;
   endfunction
   initial begin
      reset_n = 1'b0;
      clear_in();
      #1;
      check("reset_ctl", 32'(ctl), 32'(C_INIT));
      check("reset_timeout", 32'(dmem_timeout), 32'd0);
      check("reset_stall_cnt", stall_cycles, 32'd0);
      check("reset_flush_cnt", flush_events, 32'd0);
      cyc();
      cyc();
      reset_n = 1'b1;
      // hazard inputs must be ignored while clearing the pipeline
      EX_branch_taken = 1'b1; MEM_mem_req = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("init_cycle%0d", i + 1), 32'(ctl), 32'(C_INIT));
         cyc();
         #1;
      end
      check("init_stall_cnt", stall_cycles, 32'd0);
      clear_in();
      #1;
      check("run_after_init", 32'(ctl), 32'(C_RUN));
      // load-use through rs2
      EX_cntl_MemRead = 1'b1; EX_WriteRegNum = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
      #1;
      check("load_use_rs2", 32'(ctl), 32'(C_LU));
      exp_stall++;
      cyc();
      clear_in();
      #1;
      check("after_load_use", 32'(ctl), 32'(C_RUN));
      check("stall_cnt_lu", stall_cycles, pv(exp_stall));
      // load-use through rs1
      EX_cntl_MemRead = 1'b1; EX_WriteRegNum = 5'd9; ID_rs1 = 5'd9; ID_uses_rs1 = 1'b1;
      #1;
      check("load_use_rs1", 32'(ctl), 32'(C_LU));
      exp_stall++;
      cyc();
      // matching index but operand not read
      ID_uses_rs1 = 1'b0;
      #1;
      check("no_use_no_stall", 32'(ctl), 32'(C_RUN));
      // destination x0
      EX_WriteRegNum = 5'd0; ID_rs2 = 5'd0; ID_uses_rs2 = 1'b1; ID_rs1 = 5'd0; ID_uses_rs1 = 1'b1;
      #1;
      check("x0_no_stall", 32'(ctl), 32'(C_RUN));
      // not a load
      EX_cntl_MemRead = 1'b0; EX_WriteRegNum = 5'd7; ID_rs1 = 5'd7;
      #1;
      check("nonload_no_stall", 32'(ctl), 32'(C_RUN));
      cyc();
      clear_in();
      // branch overrides load-use
      EX_cntl_MemRead = 1'b1; EX_WriteRegNum = 5'd5; ID_rs2 = 5'd5; ID_uses_rs2 = 1'b1;
      EX_branch_taken = 1'b1;
      #1;
      check("branch_over_lu", 32'(ctl), 32'(C_BR));
      exp_flush++;
      cyc();
      clear_in();
      #1;
      check("after_branch", 32'(ctl), 32'(C_RUN));
      check("flush_cnt_br", flush_events, pv(exp_flush));
      check("stall_cnt_br", stall_cycles, pv(exp_stall));
      // three-cycle data memory wait
      MEM_mem_req = 1'b1; dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("mem_stall%0d", i + 1), 32'(ctl), 32'(C_STALL));
         exp_stall++;
         cyc();
      end
      dmem_ready = 1'b1;
      #1;
      check("mem_ready_resume", 32'(ctl), 32'(C_RUN));
      cyc();
      clear_in();
      #1;
      check("stall_cnt_mem", stall_cycles, pv(exp_stall));
      // branch held during a two-cycle wait, flushed once on the ready cycle
      MEM_mem_req = 1'b1; dmem_ready = 1'b0; EX_branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("br_in_stall%0d", i + 1), 32'(ctl), 32'(C_STALL));
         exp_stall++;
         cyc();
      end
      dmem_ready = 1'b1;
      #1;
      check("br_on_ready", 32'(ctl), 32'(C_BR));
      exp_flush++;
      cyc();
      clear_in();
      #1;
      check("after_br_ready", 32'(ctl), 32'(C_RUN));
      check("flush_cnt_held", flush_events, pv(exp_flush));
      check("stall_cnt_held", stall_cycles, pv(exp_stall));
      check("no_timeout_yet", 32'(dmem_timeout), 32'd0);
      // timeout after eight consecutive wait cycles
      MEM_mem_req = 1'b1; dmem_ready = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         #1;
         check($sformatf("to_stall%0d", k), 32'(ctl), 32'(C_STALL));
         check($sformatf("to_flag%0d", k), 32'(dmem_timeout), (k == 9) ? 32'd1 : 32'd0);
         exp_stall++;
         cyc();
      end
      dmem_ready = 1'b1;
      #1;
      check("to_ready_resume", 32'(ctl), 32'(C_RUN));
      check("to_sticky_ready", 32'(dmem_timeout), 32'd1);
      cyc();
      clear_in();
      #1;
      check("to_sticky_after", 32'(dmem_timeout), 32'd1);
      check("stall_cnt_to", stall_cycles, pv(exp_stall));
      // asynchronous reset in the middle of a wait
      MEM_mem_req = 1'b1; dmem_ready = 1'b0;
      #1;
      check("pre_reset_stall", 32'(ctl), 32'(C_STALL));
      cyc();
      #1;
      reset_n = 1'b0;
      #1;
      check("async_reset_ctl", 32'(ctl), 32'(C_INIT));
      check("async_reset_to", 32'(dmem_timeout), 32'd0);
      check("async_reset_stall", stall_cycles, 32'd0);
      check("async_reset_flush", flush_events, 32'd0);
      cyc();
      reset_n = 1'b1;
      #1;
      check("reinit_ctl", 32'(ctl), 32'(C_INIT));
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
